berlekamp_massey: RTL and testbench
===================================

BERLEKAMP_MASSEY -- requirements
Module: berlekamp_massey

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Start  input  1  single-cycle request; Syndrome1..Syndrome16 are valid in the same cycle.
REQ-004 Syndrome1..Syndrome16  input  8 each  syndrome sequence; Syndromek = r(alpha^(k-1)) over GF(2^8).
REQ-005 Sigma1..Sigma8  output  8 each  error-locator coefficients with Sigma0 = 01h implied; feeds error_Locations.
REQ-006 Degree  output  4  final locator length L, 0..8; saturates at 9 on failure.
REQ-007 Busy  output  1  high from the cycle after Start is captured until Done.
REQ-008 Done  output  1  one-cycle pulse when the outputs are updated.
REQ-009 Fail  output  1  valid with Done; high means uncorrectable (L > 8).

Function
REQ-010 Field SHALL be GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (11Dh) and alpha = 02h.
REQ-011 FSM SHALL have states IDLE, ITER, INV, SCALE.
- IDLE->ITER on Start.
- ITER->INV after 16 iterations.
- INV->SCALE after 7 cycles.
- SCALE->IDLE after 1 cycle.
REQ-012 On Start in IDLE, the block SHALL capture all 16 syndromes and initialise: sigma = 1, B = 1, L = 0, gamma = 01h, r = 0.
REQ-013 Each ITER cycle r (0..15) SHALL run one inversionless BM step:
- delta = XOR over i=0..8 of sigma_i * Syndrome(r+1-i); terms with r+1-i < 1 are omitted.
- sigma <= gamma*sigma + delta*x*B.
- If delta != 0 and 2L <= r: B <= old sigma, L <= r+1-L, gamma <= delta.
- Otherwise: B <= x*B.
REQ-014 sigma and B SHALL hold coefficients 0..8; higher terms are discarded. L SHALL be 5 bits wide.
REQ-015 INV SHALL compute sigma0^-1 = sigma0^254 as 7 steps of sq <= sq*sq, acc <= acc*sq, starting from sq = sigma0, acc = 01h.
REQ-016 SCALE SHALL:
- register Sigmaj = sigma_j * acc for j = 1..8;
- set Degree = min(L, 9) and Fail = (L > 8);
- pulse Done in the following cycle.
REQ-017 Latency: Done SHALL assert exactly 25 rising edges after the edge that captures Start.
REQ-018 Start SHALL be ignored while Busy; no queuing.
REQ-019 Outputs SHALL hold their last values until the next SCALE; they do not change during computation.
REQ-020 All-zero syndromes SHALL give Sigma1..8 = 00h, Degree = 0, Fail = 0.
REQ-021 If sigma0 = 00h at INV, the block SHALL force Fail = 1 and output Sigma1..8 = 00h.

Reset
REQ-022 Reset SHALL immediately clear the following:
- FSM -> IDLE;
- Sigma1..8, Degree, Busy, Done, Fail -> 0;
- internal sigma, B, L, gamma, r, and the syndrome registers -> 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no Done pulse. The first Start after deassertion SHALL be accepted normally.

Structure
REQ-024 Shared package rs_pkg SHALL hold: GF_POLY = 8'h1D, T = 8, NSYN = 16, the FSM state enum, and the latency constant 25.
REQ-025 GF multiplication SHALL be a combinational sub-module gf256_mult (two 8-bit inputs, 8-bit product), instantiated for the discrepancy, update, inversion and scaling datapaths.

Verification
REQ-026 Syndromes all 00h, Start -> after 25 edges: Done = 1, Sigma1..8 = 00h, Degree = 0, Fail = 0.
REQ-027 Syndromes all 01h (single error, locator 1) -> Sigma1 = 01h, Sigma2..8 = 00h, Degree = 1, Fail = 0.
REQ-028 Syndromes 01,02,04,08,10,20,40,80,1D,3A,74,E8,CD,87,13,26 -> Sigma1 = 02h, others 00h, Degree = 1.
REQ-029 Syndromes 00,03,05,09,11,21,41,81,1C,3B,75,E9,CC,86,12,27 -> Sigma1 = 03h, Sigma2 = 02h, others 00h, Degree = 2.
REQ-030 Random errors, 1..8 and then 9 distinct locations, compared against a software BM model -> exact Sigma match for <= 8 errors; Fail = 1 and Degree = 9 for 9 errors.
REQ-031 Reset pulsed at ITER r = 7 -> no Done, all outputs 0. Start re-issued during Busy -> ignored. Next clean Start -> correct result at 25 edges.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the Reed-Solomon decoder datapath blocks.
//   GF_POLY   : low byte of the GF(2^8) field polynomial x^8+x^4+x^3+x^2+1
//   T         : correction capability (locator coefficients 1..T)
//   NSYN      : number of syndromes (2T)
//   INV_STEPS : square-and-multiply steps that form sigma0^254
//   LATENCY   : rising edges from the Start capture edge to Done
//   state_t   : Berlekamp-Massey controller states
package rs_pkg;

    localparam logic [7:0]  GF_POLY   = 8'h1D;
    localparam int unsigned T         = 8;
    localparam int unsigned NSYN      = 16;
    localparam int unsigned INV_STEPS = 7;
    localparam int unsigned LATENCY   = 25;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        INV,
        SCALE
    } state_t;

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(2^8) multiplier (field polynomial 11Dh).
//   i_a, i_b : 8-bit operands
//   o_p      : 8-bit product i_a * i_b
module gf256_mult
    import rs_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_shift;
    logic [7:0] w_prod;

    // Shift-and-add: w_shift walks through i_a * alpha^k, reduced each step.
    always_comb begin
        w_shift = i_a;
        w_prod  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (i_b[k]) begin
                w_prod = w_prod ^ w_shift;
            end
            w_shift = {w_shift[6:0], 1'b0} ^ (w_shift[7] ? GF_POLY : 8'h00);
        end
    end

    assign o_p = w_prod;

endmodule

// File: rtl/berlekamp_massey.sv
// Inversionless Berlekamp-Massey error-locator solver for RS(255,239) style
// codes over GF(2^8). One BM step per cycle for 16 syndromes, then sigma0 is
// inverted (sigma0^254) and the locator is normalised so that Sigma0 = 01h.
//   Clk, Reset              : clock, asynchronous active-high reset
//   Start                   : one-cycle request, syndromes valid with it
//   Syndrome1..Syndrome16   : syndrome sequence S1..S16
//   Sigma1..Sigma8          : normalised locator coefficients (Sigma0 = 01h)
//   Degree                  : locator length L, saturating at 9
//   Busy                    : computation in progress
//   Done                    : one-cycle pulse when outputs have been updated
//   Fail                    : uncorrectable (L > 8 or sigma0 = 0), valid with Done
module berlekamp_massey
    import rs_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Syndrome1,
    input  logic [7:0] Syndrome2,
    input  logic [7:0] Syndrome3,
    input  logic [7:0] Syndrome4,
    input  logic [7:0] Syndrome5,
    input  logic [7:0] Syndrome6,
    input  logic [7:0] Syndrome7,
    input  logic [7:0] Syndrome8,
    input  logic [7:0] Syndrome9,
    input  logic [7:0] Syndrome10,
    input  logic [7:0] Syndrome11,
    input  logic [7:0] Syndrome12,
    input  logic [7:0] Syndrome13,
    input  logic [7:0] Syndrome14,
    input  logic [7:0] Syndrome15,
    input  logic [7:0] Syndrome16,
    output logic [7:0] Sigma1,
    output logic [7:0] Sigma2,
    output logic [7:0] Sigma3,
    output logic [7:0] Sigma4,
    output logic [7:0] Sigma5,
    output logic [7:0] Sigma6,
    output logic [7:0] Sigma7,
    output logic [7:0] Sigma8,
    output logic [3:0] Degree,
    output logic       Busy,
    output logic       Done,
    output logic       Fail
);

    state_t     r_state;
    state_t     w_state_nx;

    logic [7:0] r_syn     [NSYN];
    logic [7:0] r_sigma   [T+1];
    logic [7:0] r_b       [T+1];
    logic [4:0] r_l;
    logic [7:0] r_gamma;
    logic [3:0] r_r;
    logic [2:0] r_inv_cnt;
    logic [7:0] r_sq;
    logic [7:0] r_acc;

    logic [7:0] r_sig_out [T];
    logic [3:0] r_degree;
    logic       r_busy;
    logic       r_done;
    logic       r_done_pend;
    logic       r_fail;

    logic [7:0] w_syn_in  [NSYN];
    logic [7:0] w_dsyn    [T+1];
    logic [7:0] w_dprod   [T+1];
    logic [7:0] w_delta;
    logic [7:0] w_gs      [T+1];
    logic [7:0] w_db      [1:T];
    logic [7:0] w_sig_nx  [T+1];
    logic [7:0] w_sq_src;
    logic [7:0] w_acc_src;
    logic [7:0] w_sq2;
    logic [7:0] w_acc_nx;
    logic [7:0] w_scaled  [T];
    logic       w_sig0_zero;
    logic       w_len_change;
    logic       w_capture;
    logic       w_iter;
    logic       w_inv;
    logic       w_scale;

    assign w_syn_in = '{Syndrome1,  Syndrome2,  Syndrome3,  Syndrome4,
                        Syndrome5,  Syndrome6,  Syndrome7,  Syndrome8,
                        Syndrome9,  Syndrome10, Syndrome11, Syndrome12,
                        Syndrome13, Syndrome14, Syndrome15, Syndrome16};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    // IDLE can be re-entered while Busy is still high (SCALE -> Done gap),
    // so a Start in that cycle must not be taken.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (Start && !r_busy)                     w_state_nx = ITER;
            ITER:    if (r_r == 4'(NSYN - 1))                  w_state_nx = INV;
            INV:     if (r_inv_cnt == 3'(INV_STEPS - 1))       w_state_nx = SCALE;
            SCALE:                                             w_state_nx = IDLE;
            default:                                           w_state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_capture = (r_state == IDLE) && Start && !r_busy;
        w_iter    = (r_state == ITER);
        w_inv     = (r_state == INV);
        w_scale   = (r_state == SCALE);
    end

    // ---------------- discrepancy ----------------
    // delta = sum sigma_i * S(r+1-i); S(k) lives at r_syn[k-1], so the index is r-i.
    always_comb begin
        for (int unsigned i = 0; i <= T; i++) begin
            w_dsyn[i] = (4'(i) <= r_r) ? r_syn[r_r - 4'(i)] : '0;
        end
    end

    for (genvar g = 0; g <= T; g++) begin : g_delta
        gf256_mult u_mul (.i_a(r_sigma[g]), .i_b(w_dsyn[g]), .o_p(w_dprod[g]));
    end

    always_comb begin
        w_delta = '0;
        for (int unsigned i = 0; i <= T; i++) begin
            w_delta = w_delta ^ w_dprod[i];
        end
    end

    // ---------------- locator update: gamma*sigma + delta*x*B ----------------
    for (genvar g = 0; g <= T; g++) begin : g_gsig
        gf256_mult u_mul (.i_a(r_gamma), .i_b(r_sigma[g]), .o_p(w_gs[g]));
    end

    for (genvar g = 1; g <= T; g++) begin : g_dxb
        gf256_mult u_mul (.i_a(w_delta), .i_b(r_b[g-1]), .o_p(w_db[g]));
    end

    always_comb begin
        w_sig_nx[0] = w_gs[0];
        for (int unsigned j = 1; j <= T; j++) begin
            w_sig_nx[j] = w_gs[j] ^ w_db[j];
        end
        w_len_change = (w_delta != 8'h00) && ({r_l, 1'b0} <= {2'b00, r_r});
    end

    // ---------------- inversion: sigma0^254 ----------------
    // The square feeds the accumulator in the same step, so after 7 steps
    // acc = s^(2+4+...+128) = s^254. Step 0 seeds from sigma0 / 01h directly.
    assign w_sq_src  = (r_inv_cnt == '0) ? r_sigma[0] : r_sq;
    assign w_acc_src = (r_inv_cnt == '0) ? 8'h01 : r_acc;

    gf256_mult u_inv_sq  (.i_a(w_sq_src),  .i_b(w_sq_src), .o_p(w_sq2));
    gf256_mult u_inv_acc (.i_a(w_acc_src), .i_b(w_sq2),    .o_p(w_acc_nx));

    // ---------------- normalisation ----------------
    for (genvar g = 0; g < T; g++) begin : g_scale
        gf256_mult u_mul (.i_a(r_sigma[g+1]), .i_b(r_acc), .o_p(w_scaled[g]));
    end

    assign w_sig0_zero = (r_sigma[0] == 8'h00);

    // ---------------- BM datapath ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NSYN; i++) begin
                r_syn[i] <= '0;
            end
            for (int unsigned j = 0; j <= T; j++) begin
                r_sigma[j] <= '0;
                r_b[j]     <= '0;
            end
            r_l       <= '0;
            r_gamma   <= '0;
            r_r       <= '0;
            r_inv_cnt <= '0;
            r_sq      <= '0;
            r_acc     <= '0;
        end else if (w_capture) begin
            for (int unsigned i = 0; i < NSYN; i++) begin
                r_syn[i] <= w_syn_in[i];
            end
            for (int unsigned j = 1; j <= T; j++) begin
                r_sigma[j] <= '0;
                r_b[j]     <= '0;
            end
            r_sigma[0] <= 8'h01;
            r_b[0]     <= 8'h01;
            r_l        <= '0;
            r_gamma    <= 8'h01;
            r_r        <= '0;
            r_inv_cnt  <= '0;
        end else if (w_iter) begin
            for (int unsigned j = 0; j <= T; j++) begin
                r_sigma[j] <= w_sig_nx[j];
            end
            if (w_len_change) begin
                for (int unsigned j = 0; j <= T; j++) begin
                    r_b[j] <= r_sigma[j];
                end
                r_l     <= {1'b0, r_r} + 5'd1 - r_l;
                r_gamma <= w_delta;
            end else begin
                r_b[0] <= '0;
                for (int unsigned j = 1; j <= T; j++) begin
                    r_b[j] <= r_b[j-1];
                end
            end
            r_r <= r_r + 4'd1;
        end else if (w_inv) begin
            r_sq      <= w_sq2;
            r_acc     <= w_acc_nx;
            r_inv_cnt <= r_inv_cnt + 3'd1;
        end
    end

    // ---------------- result registers and handshake ----------------
    // Done trails SCALE by one cycle; Busy drops together with Done.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned j = 0; j < T; j++) begin
                r_sig_out[j] <= '0;
            end
            r_degree    <= '0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_done_pend <= w_scale;
            r_done      <= r_done_pend;
            if (w_capture) begin
                r_busy <= 1'b1;
            end else if (r_done_pend) begin
                r_busy <= 1'b0;
            end
            if (w_scale) begin
                for (int unsigned j = 0; j < T; j++) begin
                    r_sig_out[j] <= w_sig0_zero ? 8'h00 : w_scaled[j];
                end
                r_degree <= (r_l > 5'd9) ? 4'd9 : r_l[3:0];
                r_fail   <= (r_l > 5'd8) || w_sig0_zero;
            end
        end
    end

    assign Sigma1 = r_sig_out[0];
    assign Sigma2 = r_sig_out[1];
    assign Sigma3 = r_sig_out[2];
    assign Sigma4 = r_sig_out[3];
    assign Sigma5 = r_sig_out[4];
    assign Sigma6 = r_sig_out[5];
    assign Sigma7 = r_sig_out[6];
    assign Sigma8 = r_sig_out[7];
    assign Degree = r_degree;
    assign Busy   = r_busy;
    assign Done   = r_done;
    assign Fail   = r_fail;

endmodule

// File: tb/tb_berlekamp_massey.sv
// Self-checking bench for berlekamp_massey: known vectors, random error
// patterns against a classical (normalising) Berlekamp-Massey model,
// back-to-back operation with ignored Start, and reset abort.
module tb_berlekamp_massey;

    typedef logic [7:0][7:0] sig_t;
    typedef struct packed {
        sig_t       sig;
        logic [3:0] deg;
        logic       fail;
        logic       chk_sig;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] syn     [16];
    logic [7:0] sigma_o [8];
    logic [3:0] Degree;
    logic       Busy;
    logic       Done;
    logic       Fail;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb [$];

    always #5 Clk = ~Clk;

    berlekamp_massey dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Syndrome1(syn[0]),   .Syndrome2(syn[1]),   .Syndrome3(syn[2]),   .Syndrome4(syn[3]),
        .Syndrome5(syn[4]),   .Syndrome6(syn[5]),   .Syndrome7(syn[6]),   .Syndrome8(syn[7]),
        .Syndrome9(syn[8]),   .Syndrome10(syn[9]),  .Syndrome11(syn[10]), .Syndrome12(syn[11]),
        .Syndrome13(syn[12]), .Syndrome14(syn[13]), .Syndrome15(syn[14]), .Syndrome16(syn[15]),
        .Sigma1(sigma_o[0]), .Sigma2(sigma_o[1]), .Sigma3(sigma_o[2]), .Sigma4(sigma_o[3]),
        .Sigma5(sigma_o[4]), .Sigma6(sigma_o[5]), .Sigma7(sigma_o[6]), .Sigma8(sigma_o[7]),
        .Degree(Degree), .Busy(Busy), .Done(Done), .Fail(Fail)
    );

    // Carry-less product followed by polynomial reduction by 11Dh.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] a, input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < (e % 255); i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic sig_t cur_sig();
        sig_t v;
        for (int j = 0; j < 8; j++) v[j] = sigma_o[j];
        return v;
    endfunction

    // Classical Massey algorithm with explicit division; C(x) stays monic-at-0.
    task automatic bm_model(output exp_t e);
        logic [7:0] c [33];
        logic [7:0] bb [33];
        logic [7:0] t [33];
        logic [7:0] d, b, coef;
        int l, m;
        for (int i = 0; i < 33; i++) begin c[i] = 8'h00; bb[i] = 8'h00; end
        c[0] = 8'h01; bb[0] = 8'h01; b = 8'h01; l = 0; m = 1;
        for (int n = 0; n < 16; n++) begin
            d = syn[n];
            for (int i = 1; i <= l && i <= n; i++) d = d ^ gmul(c[i], syn[n-i]);
            if (d == 8'h00) begin
                m++;
            end else begin
                t = c;
                coef = gmul(d, gpow(b, 254));
                for (int i = 0; i + m < 33; i++) c[i+m] = c[i+m] ^ gmul(coef, bb[i]);
                if (2 * l <= n) begin
                    l = n + 1 - l; bb = t; b = d; m = 1;
                end else begin
                    m++;
                end
            end
        end
        e.fail    = (l > 8);
        e.deg     = (l > 8) ? 4'd9 : 4'(l);
        e.chk_sig = (l <= 8);
        for (int j = 0; j < 8; j++) e.sig[j] = c[j+1];
    endtask

    // Syndromes of nerr errors at distinct random positions with random values.
    task automatic make_syn(input int nerr);
        int         loc [9];
        logic [7:0] val [9];
        bit         dup;
        for (int j = 0; j < nerr; j++) begin
            do begin
                loc[j] = int'($urandom_range(0, 254));
                dup = 1'b0;
                for (int q = 0; q < j; q++) if (loc[q] == loc[j]) dup = 1'b1;
            end while (dup);
            val[j] = 8'($urandom_range(1, 255));
        end
        for (int k = 0; k < 16; k++) begin
            syn[k] = 8'h00;
            for (int j = 0; j < nerr; j++) syn[k] = syn[k] ^ gmul(val[j], gpow(8'h02, loc[j] * k));
        end
    endtask

    task automatic issue(input bit push_exp, input exp_t e);
        @(negedge Clk);
        Start = 1'b1;
        if (push_exp) sb.push_back(e);
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    // Edges after the capture edge until Done is seen (bounded at 40).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge Clk); #1; n++;
        end while (!Done && n < 40);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0;
        for (int k = 0; k < 16; k++) syn[k] = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        n_tests++;
        if ({cur_sig(), Degree, Busy, Done, Fail} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got sig=%h deg=%0d busy=%b done=%b fail=%b want all 0",
                     cur_sig(), Degree, Busy, Done, Fail);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_known();
        logic [127:0] kv [4];
        logic [127:0] v;
        exp_t e, got;
        int   n;
        kv[0] = 128'h00000000000000000000000000000000;
        kv[1] = 128'h01010101010101010101010101010101;
        kv[2] = 128'h01020408102040801D3A74E8CD871326;
        kv[3] = 128'h0003050911214181_1C3B75E9CC861227;
        for (int t = 0; t < 4; t++) begin
            v = kv[t];
            for (int k = 0; k < 16; k++) syn[k] = v[8*(15-k) +: 8];
            e = '0;
            case (t)
                1: begin e.sig[0] = 8'h01; e.deg = 4'd1; end
                2: begin e.sig[0] = 8'h02; e.deg = 4'd1; end
                3: begin e.sig[0] = 8'h03; e.sig[1] = 8'h02; e.deg = 4'd2; end
                default: ;
            endcase
            issue(1'b1, e);
            n_tests++;
            if (Busy !== 1'b1) begin
                n_fail++; $display("FAIL known%0d busy: got %b want 1", t, Busy);
            end
            wait_done(n);
            n_tests++;
            if (n !== 25) begin
                n_fail++; $display("FAIL known%0d latency: got %0d want 25", t, n);
            end
            if (sb.size() == 0) begin
                n_tests++; n_fail++; $display("FAIL known%0d scoreboard: got empty want entry", t);
            end else begin
                got = sb.pop_front();
                n_tests++;
                if ({cur_sig(), Degree, Fail} !== {got.sig, got.deg, got.fail}) begin
                    n_fail++;
                    $display("FAIL known%0d result: got sig=%h deg=%0d fail=%b want sig=%h deg=%0d fail=%b",
                             t, cur_sig(), Degree, Fail, got.sig, got.deg, got.fail);
                end
            end
            @(posedge Clk); #1;
            n_tests++;
            if ({Done, Busy} !== 2'b00) begin
                n_fail++; $display("FAIL known%0d done_pulse: got done=%b busy=%b want 0 0", t, Done, Busy);
            end
        end
    endtask

    task automatic test_random();
        exp_t e, got;
        int   n;
        for (int nerr = 1; nerr <= 9; nerr++) begin
            make_syn(nerr);
            bm_model(e);
            issue(1'b1, e);
            wait_done(n);
            n_tests++;
            if (n !== 25) begin
                n_fail++; $display("FAIL rand%0d latency: got %0d want 25", nerr, n);
            end
            if (sb.size() == 0) begin
                n_tests++; n_fail++; $display("FAIL rand%0d scoreboard: got empty want entry", nerr);
            end else begin
                got = sb.pop_front();
                n_tests++;
                if ({Degree, Fail} !== {got.deg, got.fail}) begin
                    n_fail++;
                    $display("FAIL rand%0d degree: got deg=%0d fail=%b want deg=%0d fail=%b",
                             nerr, Degree, Fail, got.deg, got.fail);
                end
                if (got.chk_sig) begin
                    n_tests++;
                    if (cur_sig() !== got.sig) begin
                        n_fail++; $display("FAIL rand%0d sigma: got %h want %h", nerr, cur_sig(), got.sig);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        logic [68:0] prev;
        int   n, changed, dones;
        make_syn(3);
        bm_model(e);
        issue(1'b1, e);
        wait_done(n);
        if (sb.size() != 0) got = sb.pop_front();
        n_tests++;
        if (cur_sig() !== got.sig) begin
            n_fail++; $display("FAIL b2b_first sigma: got %h want %h", cur_sig(), got.sig);
        end
        prev = {cur_sig(), Degree, Fail};
        make_syn(5);
        bm_model(e);
        issue(1'b1, e);
        changed = 0; n = 0;
        do begin
            @(posedge Clk); #1; n++;
            if (n <= 23 && {cur_sig(), Degree, Fail} !== prev) changed++;
            if (n == 6) begin Start = 1'b1; syn[0] = syn[0] ^ 8'h5A; end
            if (n == 7) Start = 1'b0;
        end while (!Done && n < 40);
        n_tests++;
        if (n !== 25) begin
            n_fail++; $display("FAIL b2b_latency: got %0d want 25", n);
        end
        n_tests++;
        if (changed !== 0) begin
            n_fail++; $display("FAIL b2b_hold: got %0d changed cycles want 0", changed);
        end
        if (sb.size() != 0) got = sb.pop_front();
        n_tests++;
        if ({cur_sig(), Degree, Fail} !== {got.sig, got.deg, got.fail}) begin
            n_fail++;
            $display("FAIL b2b_second result: got sig=%h deg=%0d fail=%b want sig=%h deg=%0d fail=%b",
                     cur_sig(), Degree, Fail, got.sig, got.deg, got.fail);
        end
        dones = 0;
        repeat (30) begin @(posedge Clk); #1; if (Done) dones++; end
        n_tests++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL b2b_ignored_start: got %0d extra Done want 0", dones);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e, got;
        int   n, dones;
        make_syn(4);
        bm_model(e);
        issue(1'b1, e);
        repeat (7) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        sb.delete();
        n_tests++;
        if ({cur_sig(), Degree, Busy, Done, Fail} !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: got sig=%h deg=%0d busy=%b done=%b fail=%b want all 0",
                     cur_sig(), Degree, Busy, Done, Fail);
        end
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        dones = 0;
        repeat (30) begin @(posedge Clk); #1; if (Done) dones++; end
        n_tests++;
        if (dones !== 0 || {cur_sig(), Degree, Fail} !== '0) begin
            n_fail++; $display("FAIL abort_no_done: got dones=%0d sig=%h want 0 0", dones, cur_sig());
        end
        make_syn(6);
        bm_model(e);
        issue(1'b1, e);
        wait_done(n);
        n_tests++;
        if (n !== 25) begin
            n_fail++; $display("FAIL abort_restart latency: got %0d want 25", n);
        end
        if (sb.size() == 0) begin
            n_tests++; n_fail++; $display("FAIL abort_restart scoreboard: got empty want entry");
        end else begin
            got = sb.pop_front();
            n_tests++;
            if ({cur_sig(), Degree, Fail} !== {got.sig, got.deg, got.fail}) begin
                n_fail++;
                $display("FAIL abort_restart result: got sig=%h deg=%0d fail=%b want sig=%h deg=%0d fail=%b",
                         cur_sig(), Degree, Fail, got.sig, got.deg, got.fail);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
